// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants, requester indices and arbiter state encoding
package mem_arbiter_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH = 256;
  localparam int MEM_WIDTH = 16;
  localparam int REQ_REWARD = 0;
  localparam int REQ_QUPDATE = 1;
  localparam int REQ_FETCH = 2;
  typedef enum logic {IDLE, OWN} arb_state_t;
endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting after last_owner
module rr_pick
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int LW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [LW-1:0]      last_owner,
  input  logic [NUM_REQ-1:0] exclude,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  logic [NUM_REQ-1:0] cand;
  assign cand = req & ~exclude;
  assign valid = |cand;
  // scan farthest-first so the nearest candidate after last_owner overwrites
  always_comb begin
    winner = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (cand[(int'(last_owner) + k) % NUM_REQ]) winner = NUM_REQ'(1) << ((int'(last_owner) + k) % NUM_REQ);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin burst arbiter for the shared mem port; MEM_ARB_TIMEOUT_EN enables hold-timeout preemption
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WORD_WIDTH = mem_arbiter_pkg::WORD_WIDTH,
  parameter int MAX_HOLD = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]              req_wr_en,
  input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic [WORD_WIDTH-1:0]           rd_data,
  output logic [NUM_REQ-1:0]              preempt,
  output logic [WORD_WIDTH-1:0]           mem_address,
  output logic                            mem_wr_en,
  output logic [WORD_WIDTH-1:0]           mem_data_in,
  input  logic [WORD_WIDTH-1:0]           mem_data_out
);
  localparam int LW = $clog2(NUM_REQ);
  arb_state_t state;
  logic [LW-1:0] last_owner, pick_idx;
  logic [NUM_REQ-1:0] issue, pick, excl;
  logic pick_valid, arb, rotate;
  assign issue = gnt & req;
  assign rd_data = mem_data_out;
  assign arb = state == IDLE || !req[last_owner] || rotate;
  assign excl = rotate ? gnt : '0;
  rr_pick #(.NUM_REQ(NUM_REQ), .LW(LW)) u_pick (
    .req(req),
    .last_owner(last_owner),
    .exclude(excl),
    .winner(pick),
    .valid(pick_valid)
  );
  // one-hot winner to index for last_owner
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = LW'(i);
  end
  // route the active requester's slice onto the memory port, zero when nobody issues
  always_comb begin
    mem_address = '0;
    mem_wr_en = 1'b0;
    mem_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (issue[i]) begin
        mem_address = req_addr[i*WORD_WIDTH +: WORD_WIDTH];
        mem_wr_en = req_wr_en[i];
        mem_data_in = req_wdata[i*WORD_WIDTH +: WORD_WIDTH];
      end
  end
  // ownership FSM with registered grant and read-valid pipeline
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      gnt <= '0;
      rd_valid <= '0;
      last_owner <= LW'(NUM_REQ - 1);
    end else begin
      rd_valid <= issue & ~req_wr_en;
      if (arb) begin
        state <= pick_valid ? OWN : IDLE;
        gnt <= pick;
        if (pick_valid) last_owner <= pick_idx;
      end
    end
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] hold;
  assign rotate = state == OWN && req[last_owner] && hold == CW'(MAX_HOLD - 1) && |(req & ~gnt);
  // count owned cycles, saturating at the limit; restart on each new grant
  always_ff @(posedge clock)
    if (reset) begin
      hold <= '0;
      preempt <= '0;
    end else begin
      preempt <= rotate ? gnt : '0;
      hold <= (arb && pick_valid) ? '0 : (state == OWN && hold != CW'(MAX_HOLD - 1)) ? hold + 1'b1 : hold;
    end
`else
  assign rotate = 1'b0;
  assign preempt = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven directed checks of mem_arbiter against a behavioural one-cycle memory
module tb_mem_arbiter;
  logic clock = 1'b0;
  logic reset;
  logic [2:0] req, req_wr_en, gnt, rd_valid, preempt;
  logic [47:0] req_addr, req_wdata;
  logic [15:0] rd_data, mem_address, mem_data_in, mem_data_out;
  logic mem_wr_en;
  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_bad = 0;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  typedef struct {
    logic rst;
    logic [2:0] rq, we;
    logic [15:0] a0, a1, a2, wd;
    logic [2:0] e_gnt, e_rv;
    logic [15:0] e_rd, e_addr;
    logic e_we;
    logic [15:0] e_din;
  } vec_t;
  vec_t tbl[$];

  mem_arbiter #(.NUM_REQ(3), .WORD_WIDTH(16), .MAX_HOLD(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_wr_en(req_wr_en),
    .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .preempt(preempt),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_wr_en) mem[mem_address[7:0]] <= mem_data_in;
    mem_data_out <= mem[mem_address[7:0]];
  end

  function automatic vec_t v(logic r, logic [2:0] rq, we, logic [15:0] a0, a1, a2, wd,
                             logic [2:0] eg, erv, logic [15:0] erd, eaddr, logic ewe, logic [15:0] edin);
    v = '{r, rq, we, a0, a1, a2, wd, eg, erv, erd, eaddr, ewe, edin};
  endfunction

  task automatic chk(string nm, logic [15:0] got, logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(logic r, logic [2:0] rq, we, logic [15:0] a0, a1, a2, wd);
    @(negedge clock);
    reset = r;
    req = rq;
    req_wr_en = we;
    req_addr = {a2, a1, a0};
    for (int i = 0; i < 3; i++) req_wdata[i*16 +: 16] = we[i] ? wd : 16'h5A5A;
    #1;
  endtask

  task automatic chk_state(string tag, logic [2:0] eg, erv, epre, logic [15:0] erd, eaddr);
    chk({tag, " gnt"}, {13'd0, gnt}, {13'd0, eg});
    chk({tag, " rd_valid"}, {13'd0, rd_valid}, {13'd0, erv});
    chk({tag, " preempt"}, {13'd0, preempt}, {13'd0, epre});
    chk({tag, " onehot"}, {15'd0, $onehot0(gnt)}, 16'd1);
    if (erv != 3'b000) chk({tag, " rd_data"}, rd_data, erd);
    chk({tag, " mem_address"}, mem_address, eaddr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    reset = 1'b1; req = '0; req_wr_en = '0; req_addr = '0; req_wdata = '0;
    // single requester: reads at 5 and 6
    tbl.push_back(v(0, 3'b001, 3'b000,  5,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b001, 3'b000,  5,  0,  0, 0, 3'b001, 3'b000, 16'h0000,  5, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b001, 3'b000,  6,  0,  0, 0, 3'b001, 3'b001, 16'h1005,  6, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b001, 3'b001, 16'h1006,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    // reset, then three-way contention: order 0,1,2,0
    tbl.push_back(v(1, 3'b000, 3'b000,  0,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b111, 3'b000, 10, 20, 30, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b111, 3'b000, 10, 20, 30, 0, 3'b001, 3'b000, 16'h0000, 10, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b111, 3'b000, 11, 20, 30, 0, 3'b001, 3'b001, 16'h100A, 11, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b110, 3'b000, 11, 20, 30, 0, 3'b001, 3'b001, 16'h100B,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b111, 3'b000, 11, 20, 30, 0, 3'b010, 3'b000, 16'h0000, 20, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b111, 3'b000, 11, 21, 30, 0, 3'b010, 3'b010, 16'h1014, 21, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b101, 3'b000, 11, 21, 30, 0, 3'b010, 3'b010, 16'h1015,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b111, 3'b000, 11, 21, 30, 0, 3'b100, 3'b000, 16'h0000, 30, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b111, 3'b000, 11, 21, 31, 0, 3'b100, 3'b100, 16'h101E, 31, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b011, 3'b000, 11, 21, 31, 0, 3'b100, 3'b100, 16'h101F,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b001, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    // requester 1 writes BEEF to 12 then reads it back
    tbl.push_back(v(0, 3'b010, 3'b010,  0, 12,  0, 16'hBEEF, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b010, 3'b010,  0, 12,  0, 16'hBEEF, 3'b010, 3'b000, 16'h0000, 12, 1, 16'hBEEF));
    tbl.push_back(v(0, 3'b010, 3'b000,  0, 12,  0, 0, 3'b010, 3'b000, 16'h0000, 12, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b010, 3'b010, 16'hBEEF,  0, 0, 16'h0000));
    // handoff: requester 0's last read, then 1 takes over with no gap
    tbl.push_back(v(0, 3'b001, 3'b000, 40,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b011, 3'b000, 40, 50,  0, 0, 3'b001, 3'b000, 16'h0000, 40, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b010, 3'b000, 40, 50,  0, 0, 3'b001, 3'b001, 16'h1028,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b010, 3'b000, 40, 50,  0, 0, 3'b010, 3'b000, 16'h0000, 50, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b010, 3'b010, 16'h1032,  0, 0, 16'h0000));
    // reset during requester 2's read: no valid afterwards, requester 0 wins first
    tbl.push_back(v(0, 3'b100, 3'b000,  0,  0, 60, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b100, 3'b000,  0,  0, 60, 0, 3'b100, 3'b000, 16'h0000, 60, 0, 16'h5A5A));
    tbl.push_back(v(1, 3'b100, 3'b000,  0,  0, 61, 0, 3'b100, 3'b100, 16'h103C, 61, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b111, 3'b000, 70, 80, 90, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b001, 3'b000, 16'h0000,  0, 0, 16'h0000));
    // write issued in the reset cycle still lands in memory
    tbl.push_back(v(0, 3'b010, 3'b000,  0, 99,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b010, 3'b000,  0, 99,  0, 0, 3'b010, 3'b000, 16'h0000, 99, 0, 16'h5A5A));
    tbl.push_back(v(1, 3'b010, 3'b010,  0, 100, 0, 16'h1234, 3'b010, 3'b010, 16'h1063, 100, 1, 16'h1234));
    tbl.push_back(v(0, 3'b001, 3'b000, 100, 0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b001, 3'b000, 100, 0,  0, 0, 3'b001, 3'b000, 16'h0000, 100, 0, 16'h5A5A));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b001, 3'b001, 16'h1234,  0, 0, 16'h0000));
    tbl.push_back(v(0, 3'b000, 3'b000,  0,  0,  0, 0, 3'b000, 3'b000, 16'h0000,  0, 0, 16'h0000));

    drive(1, 3'b000, 3'b000, 0, 0, 0, 0);
    drive(1, 3'b000, 3'b000, 0, 0, 0, 0);
    chk_state("reset", 3'b000, 3'b000, 3'b000, 16'h0000, 16'h0000);
    chk("reset mem_wr_en", {15'd0, mem_wr_en}, 16'd0);
    chk("reset mem_data_in", mem_data_in, 16'h0000);

    for (int n = 0; n < tbl.size(); n++) begin
      string tag;
      tag = $sformatf("vec%0d", n);
      drive(tbl[n].rst, tbl[n].rq, tbl[n].we, tbl[n].a0, tbl[n].a1, tbl[n].a2, tbl[n].wd);
      chk_state(tag, tbl[n].e_gnt, tbl[n].e_rv, 3'b000, tbl[n].e_rd, tbl[n].e_addr);
      chk({tag, " mem_wr_en"}, {15'd0, mem_wr_en}, {15'd0, tbl[n].e_we});
      chk({tag, " mem_data_in"}, mem_data_in, tbl[n].e_din);
    end

    // hold timeout: requester 0 keeps req while requester 1 waits
    drive(0, 3'b001, 3'b000, 200, 210, 0, 0);
    chk_state("to0", 3'b000, 3'b000, 3'b000, 16'h0, 16'd0);
    for (int c = 1; c <= 3; c++) begin
      drive(0, 3'b011, 3'b000, 200, 210, 0, 0);
      chk_state($sformatf("to%0d", c), 3'b001, (c == 1) ? 3'b000 : 3'b001, 3'b000, 16'h10C8, 16'd200);
    end
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    chk_state("to4", 3'b001, 3'b001, 3'b000, 16'h10C8, 16'd201);
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    chk_state("to5", TO ? 3'b010 : 3'b001, 3'b001, TO ? 3'b001 : 3'b000, 16'h10C9, TO ? 16'd210 : 16'd201);
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    chk_state("to6", TO ? 3'b010 : 3'b001, TO ? 3'b010 : 3'b001, 3'b000, TO ? 16'h10D2 : 16'h10C9, TO ? 16'd210 : 16'd201);
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    drive(0, 3'b011, 3'b000, 201, 210, 0, 0);
    chk_state("to9", 3'b001, TO ? 3'b010 : 3'b001, TO ? 3'b010 : 3'b000, TO ? 16'h10D2 : 16'h10C9, 16'd201);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0);
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0);
    chk_state("to_end", 3'b000, 3'b000, 3'b000, 16'h0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
